// File: rtl/nios_dbg_pkg.sv
// Shared types and constants for the NIOS debug-slave command queue.
// Optional drop counter: NIOS_DBG_SLAVE_OVF_CNT_EN.
package nios_dbg_pkg;

    localparam int unsigned DBG_SR_W       = 38;
    localparam int unsigned DBG_IR_W       = 2;
    localparam int unsigned DBG_CH_W       = 2;
    localparam int unsigned JDO_ACTION_BIT = DBG_SR_W - 1;
    localparam int unsigned SYNC_STAGES    = 3;
    localparam int unsigned OVF_CNT_W      = 8;

    typedef struct packed {
        logic [DBG_IR_W-1:0] ir;
        logic [DBG_CH_W-1:0] ch;
        logic [DBG_SR_W-1:0] sr;
    } cmd_entry_t;

endpackage

// File: rtl/nios_dbg_sync_edge.sv
// Two-flop synchronizer plus delay flop; flags the rising edge of an async level.
module nios_dbg_sync_edge
    import nios_dbg_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/nios_debug_slave_cmd_queue.sv
// Queues debug-slave update-DR commands into a FIFO and issues per-channel action pulses.
// Optional drop counter: NIOS_DBG_SLAVE_OVF_CNT_EN.
module nios_debug_slave_cmd_queue
    import nios_dbg_pkg::*;
#(
    parameter int unsigned SR_W   = 38,
    parameter int unsigned IR_W   = 2,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        vs_udr,
    input  logic                        vs_uir,
    input  logic [IR_W-1:0]             ir_in,
    input  logic [$clog2(NUM_CH)-1:0]   ch_sel,
    input  logic [SR_W-1:0]             sr,
    input  logic                        cmd_ready,
    output logic                        cmd_valid,
    output logic [SR_W-1:0]             jdo,
    output logic [IR_W-1:0]             cmd_ir,
    output logic [$clog2(NUM_CH)-1:0]   cmd_ch,
    output logic [NUM_CH-1:0]           take_action,
    output logic [NUM_CH-1:0]           take_no_action,
    output logic                        overflow,
    output logic [7:0]                  ovf_cnt
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic udr_rise_c;
    logic uir_rise_c;

    nios_dbg_sync_edge u_udr_edge (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_udr),
        .rise_c   (udr_rise_c)
    );

    nios_dbg_sync_edge u_uir_edge (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_uir),
        .rise_c   (uir_rise_c)
    );

    cmd_entry_t              mem_q [DEPTH];
    cmd_entry_t              mem_d [DEPTH];
    cmd_entry_t              head_q, head_d;
    cmd_entry_t              new_entry_c;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic                    overflow_q, overflow_d;
    logic [NUM_CH-1:0]       take_action_q, take_action_d;
    logic [NUM_CH-1:0]       take_no_action_q, take_no_action_d;
    logic                    full_c, pop_c, push_c, drop_c;

    // Head is re-registered from the post-update FIFO; it holds the last value when empty.
    always_comb begin
        full_c = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_c  = cmd_valid_q & cmd_ready;
        push_c = udr_rise_c & (~full_c | pop_c);
        drop_c = udr_rise_c & full_c & ~pop_c;

        new_entry_c.ir = DBG_IR_W'(ir_in);
        new_entry_c.ch = DBG_CH_W'(ch_sel);
        new_entry_c.sr = DBG_SR_W'(sr);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_c) begin
            mem_d[wr_ptr_q[AW-1:0]] = new_entry_c;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        cmd_valid_d = (wr_ptr_d != rd_ptr_d);
        head_d      = head_q;
        if (cmd_valid_d) begin
            head_d = mem_d[rd_ptr_d[AW-1:0]];
        end

        take_action_d    = '0;
        take_no_action_d = '0;
        if (pop_c) begin
            if (head_q.sr[JDO_ACTION_BIT]) begin
                take_action_d[CH_W'(head_q.ch)] = 1'b1;
            end else begin
                take_no_action_d[CH_W'(head_q.ch)] = 1'b1;
            end
        end

        // A drop on the same edge as a clear wins.
        overflow_d = overflow_q;
        if (uir_rise_c) begin
            overflow_d = 1'b0;
        end
        if (drop_c) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            head_q           <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            cmd_valid_q      <= 1'b0;
            overflow_q       <= 1'b0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
        end else begin
            mem_q            <= mem_d;
            head_q           <= head_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            cmd_valid_q      <= cmd_valid_d;
            overflow_q       <= overflow_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
        end
    end

    assign cmd_valid      = cmd_valid_q;
    assign jdo            = SR_W'(head_q.sr);
    assign cmd_ir         = IR_W'(head_q.ir);
    assign cmd_ch         = CH_W'(head_q.ch);
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign overflow       = overflow_q;

`ifdef NIOS_DBG_SLAVE_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    // Saturating drop counter, cleared alongside overflow.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (uir_rise_c) begin
            ovf_cnt_d = drop_c ? OVF_CNT_W'(1) : '0;
        end else if (drop_c && (ovf_cnt_q != {OVF_CNT_W{1'b1}})) begin
            ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    assign ovf_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_nios_debug_slave_cmd_queue.sv
// Directed self-checking bench for nios_debug_slave_cmd_queue.
module tb_nios_debug_slave_cmd_queue;

    logic        clk;
    logic        reset;
    logic        vs_udr;
    logic        vs_uir;
    logic [1:0]  ir_in;
    logic [1:0]  ch_sel;
    logic [37:0] sr;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [37:0] jdo;
    logic [1:0]  cmd_ir;
    logic [1:0]  cmd_ch;
    logic [3:0]  take_action;
    logic [3:0]  take_no_action;
    logic        overflow;
    logic [7:0]  ovf_cnt;

    int n_checks = 0;
    int n_errors = 0;

`ifdef NIOS_DBG_SLAVE_OVF_CNT_EN
    localparam logic [7:0] EXP_OVF_CNT = 8'd1;
`else
    localparam logic [7:0] EXP_OVF_CNT = 8'd0;
`endif

    typedef struct {
        logic [1:0]  ir;
        logic [1:0]  ch;
        logic [37:0] sr;
        logic [3:0]  ta;
        logic [3:0]  tna;
    } vec_t;

    vec_t v [6];

    nios_debug_slave_cmd_queue dut (
        .clk            (clk),
        .reset          (reset),
        .vs_udr         (vs_udr),
        .vs_uir         (vs_uir),
        .ir_in          (ir_in),
        .ch_sel         (ch_sel),
        .sr             (sr),
        .cmd_ready      (cmd_ready),
        .cmd_valid      (cmd_valid),
        .jdo            (jdo),
        .cmd_ir         (cmd_ir),
        .cmd_ch         (cmd_ch),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .overflow       (overflow),
        .ovf_cnt        (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge is detected on the 2nd tick; push lands on the 3rd edge, where cmd_ready = pop_at_push.
    task automatic udr_pulse(input vec_t e, input logic pop_at_push);
        ir_in  = e.ir;
        ch_sel = e.ch;
        sr     = e.sr;
        vs_udr = 1'b1;
        tick();
        tick();
        vs_udr    = 1'b0;
        cmd_ready = pop_at_push;
        tick();
        cmd_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic uir_pulse();
        vs_uir = 1'b1;
        tick();
        tick();
        vs_uir = 1'b0;
        tick();
        tick();
        tick();
    endtask

    // Single command with cmd_ready held high: valid after 3rd edge, pulse after 4th.
    task automatic single_cmd(input string tag, input vec_t e);
        ir_in     = e.ir;
        ch_sel    = e.ch;
        sr        = e.sr;
        cmd_ready = 1'b1;
        vs_udr    = 1'b1;
        tick();
        check_eq({tag, "_valid_c1"}, 64'(cmd_valid), 64'd0);
        tick();
        check_eq({tag, "_valid_c2"}, 64'(cmd_valid), 64'd0);
        vs_udr = 1'b0;
        tick();
        check_eq({tag, "_valid_c3"}, 64'(cmd_valid), 64'd1);
        check_eq({tag, "_jdo_c3"},   64'(jdo),       64'(e.sr));
        check_eq({tag, "_ch_c3"},    64'(cmd_ch),    64'(e.ch));
        check_eq({tag, "_ir_c3"},    64'(cmd_ir),    64'(e.ir));
        check_eq({tag, "_ta_c3"},    64'(take_action), 64'd0);
        tick();
        check_eq({tag, "_ta_pulse"},  64'(take_action),    64'(e.ta));
        check_eq({tag, "_tna_pulse"}, 64'(take_no_action), 64'(e.tna));
        check_eq({tag, "_valid_c4"},  64'(cmd_valid),      64'd0);
        check_eq({tag, "_jdo_hold"},  64'(jdo),            64'(e.sr));
        cmd_ready = 1'b0;
        tick();
        check_eq({tag, "_ta_after"},  64'(take_action),    64'd0);
        check_eq({tag, "_tna_after"}, 64'(take_no_action), 64'd0);
        tick();
        tick();
    endtask

    initial begin
        int order [4];

        v[0] = '{ir: 2'b01, ch: 2'd1, sr: 38'h20_0000_00A1, ta: 4'b0010, tna: 4'b0000};
        v[1] = '{ir: 2'b10, ch: 2'd3, sr: 38'h00_1234_5678, ta: 4'b0000, tna: 4'b1000};
        v[2] = '{ir: 2'b11, ch: 2'd0, sr: 38'h3F_FFFF_FFFF, ta: 4'b0001, tna: 4'b0000};
        v[3] = '{ir: 2'b00, ch: 2'd2, sr: 38'h10_0000_0000, ta: 4'b0000, tna: 4'b0100};
        v[4] = '{ir: 2'b01, ch: 2'd1, sr: 38'h2A_AAAA_AAAA, ta: 4'b0010, tna: 4'b0000};
        v[5] = '{ir: 2'b10, ch: 2'd3, sr: 38'h25_5555_5555, ta: 4'b1000, tna: 4'b0000};
        order = '{1, 2, 3, 5};

        reset     = 1'b1;
        vs_udr    = 1'b0;
        vs_uir    = 1'b0;
        ir_in     = '0;
        ch_sel    = '0;
        sr        = '0;
        cmd_ready = 1'b0;
        tick();
        tick();
        check_eq("rst_valid", 64'(cmd_valid),      64'd0);
        check_eq("rst_jdo",   64'(jdo),            64'd0);
        check_eq("rst_ovf",   64'(overflow),       64'd0);
        check_eq("rst_cnt",   64'(ovf_cnt),        64'd0);
        check_eq("rst_ta",    64'(take_action),    64'd0);
        check_eq("rst_tna",   64'(take_no_action), 64'd0);
        reset = 1'b0;
        tick();

        single_cmd("act", '{ir: 2'b01, ch: 2'd2, sr: 38'h20_0000_0001, ta: 4'b0100, tna: 4'b0000});
        single_cmd("noact", '{ir: 2'b10, ch: 2'd0, sr: 38'h00_0000_0005, ta: 4'b0000, tna: 4'b0001});

        // Fill four entries, fifth is dropped.
        for (int i = 0; i < 4; i++) udr_pulse(v[i], 1'b0);
        check_eq("fill4_ovf",   64'(overflow),  64'd0);
        check_eq("fill4_valid", 64'(cmd_valid), 64'd1);
        udr_pulse(v[4], 1'b0);
        check_eq("fill5_ovf",   64'(overflow), 64'd1);
        check_eq("fill5_cnt",   64'(ovf_cnt),  64'(EXP_OVF_CNT));
        check_eq("fill5_head",  64'(jdo),      64'(v[0].sr));
        check_eq("fill5_ch",    64'(cmd_ch),   64'(v[0].ch));

        uir_pulse();
        check_eq("uir_ovf",   64'(overflow),  64'd0);
        check_eq("uir_cnt",   64'(ovf_cnt),   64'd0);
        check_eq("uir_valid", 64'(cmd_valid), 64'd1);
        check_eq("uir_head",  64'(jdo),       64'(v[0].sr));

        // Full FIFO, push coincides with a pop of the head.
        udr_pulse(v[5], 1'b1);
        check_eq("fullpop_ovf",  64'(overflow), 64'd0);
        check_eq("fullpop_head", 64'(jdo),      64'(v[1].sr));

        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("drain%0d_valid", k), 64'(cmd_valid), 64'd1);
            check_eq($sformatf("drain%0d_jdo", k),   64'(jdo),       64'(v[order[k]].sr));
            check_eq($sformatf("drain%0d_ch", k),    64'(cmd_ch),    64'(v[order[k]].ch));
            check_eq($sformatf("drain%0d_ir", k),    64'(cmd_ir),    64'(v[order[k]].ir));
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
            check_eq($sformatf("drain%0d_ta", k),  64'(take_action),    64'(v[order[k]].ta));
            check_eq($sformatf("drain%0d_tna", k), 64'(take_no_action), 64'(v[order[k]].tna));
        end
        check_eq("drain_empty", 64'(cmd_valid), 64'd0);
        check_eq("drain_hold",  64'(jdo),       64'(v[5].sr));
        tick();
        check_eq("drain_ta_idle", 64'(take_action), 64'd0);

        // Reset with three queued entries and a fourth edge in flight.
        for (int i = 0; i < 3; i++) udr_pulse(v[i], 1'b0);
        check_eq("pre_rst_valid", 64'(cmd_valid), 64'd1);
        ir_in     = v[3].ir;
        ch_sel    = v[3].ch;
        sr        = v[3].sr;
        vs_udr    = 1'b1;
        tick();
        tick();
        vs_udr    = 1'b0;
        reset     = 1'b1;
        cmd_ready = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("midrst_valid", 64'(cmd_valid), 64'd0);
        check_eq("midrst_jdo",   64'(jdo),       64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("midrst_idle%0d_valid", i), 64'(cmd_valid), 64'd0);
            check_eq($sformatf("midrst_idle%0d_pulse", i),
                     64'({take_action, take_no_action}), 64'd0);
        end
        cmd_ready = 1'b0;

        single_cmd("post_rst", '{ir: 2'b01, ch: 2'd2, sr: 38'h20_0000_0001, ta: 4'b0100, tna: 4'b0000});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
